// File: rtl/uid_alloc_pkg.sv
// Shared types and helpers for the unique-ID allocator.
package uid_alloc_pkg;

    typedef enum logic {
        UID_MODE_COUNT   = 1'b0,
        UID_MODE_RECYCLE = 1'b1
    } uid_mode_e;

    // Namespace select width; a single namespace still needs one select bit.
    function automatic int ns_width(input int ns_count);
        return (ns_count <= 1) ? 1 : $clog2(ns_count);
    endfunction

endpackage

// File: rtl/uid_lowest_free.sv
// Find-first-zero over a 2**ID_W bitmap: index of the lowest clear bit plus an all-set flag.
module uid_lowest_free #(
    parameter int ID_W = 4
) (
    input  logic [2**ID_W-1:0] bits_i,
    output logic [ID_W-1:0]    idx_o,
    output logic               all_set_o
);

    // Scan from the top so the lowest clear bit is the last one to win.
    always_comb begin
        idx_o = '0;
        for (int i = 2**ID_W - 1; i >= 0; i--) begin
            if (!bits_i[i]) begin
                idx_o = ID_W'(i);
            end
        end
    end

    assign all_set_o = &bits_i;

endmodule

// File: rtl/uid_alloc.sv
// Per-namespace unique-ID allocator: monotonic counters or a lowest-first recycling pool.
module uid_alloc
    import uid_alloc_pkg::*;
#(
    parameter int        NS_COUNT = 4,
    parameter int        ID_W     = 4,
    parameter uid_mode_e MODE     = UID_MODE_COUNT,
    localparam int       NS_W     = ns_width(NS_COUNT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [NS_W-1:0]     alloc_ns,
    output logic                alloc_ready,
    output logic                rsp_valid,
    output logic [NS_W-1:0]     rsp_ns,
    output logic [ID_W-1:0]     rsp_id,
    input  logic                free_valid,
    input  logic [NS_W-1:0]     free_ns,
    input  logic [ID_W-1:0]     free_id,
    output logic                err_double_free,
    output logic [NS_COUNT-1:0] ns_full,
    output logic [NS_COUNT-1:0] ns_wrapped
);

    localparam int NS_SPAN = 2**NS_W;

    logic [NS_SPAN-1:0] ns_exists;
    logic               ns_ok;
    logic               accept;
    logic [ID_W-1:0]    issue_id;
    logic               rsp_valid_q;
    logic [NS_W-1:0]    rsp_ns_q;
    logic [ID_W-1:0]    rsp_id_q;

    // Selects beyond NS_COUNT address no namespace and are never accepted.
    for (genvar gi = 0; gi < NS_SPAN; gi++) begin : g_ns_exists
        assign ns_exists[gi] = (gi < NS_COUNT);
    end

    assign ns_ok  = ns_exists[alloc_ns];
    assign accept = alloc_valid && alloc_ready;

    if (MODE == UID_MODE_COUNT) begin : g_count
        logic [ID_W-1:0] cnt_q  [NS_COUNT];
        logic            wrap_q [NS_COUNT];
        logic            unused_free;

        assign unused_free = ^{free_valid, free_ns, free_id};

        for (genvar gi = 0; gi < NS_COUNT; gi++) begin : g_cnt
            logic            hit;
            logic [ID_W-1:0] cnt_d;
            logic            wrap_d;

            assign hit    = accept && (alloc_ns == NS_W'(gi));
            assign cnt_d  = hit ? cnt_q[gi] + 1'b1 : cnt_q[gi];
            assign wrap_d = wrap_q[gi] || (hit && (cnt_q[gi] == '1));

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q[gi]  <= '0;
                    wrap_q[gi] <= 1'b0;
                end else begin
                    cnt_q[gi]  <= cnt_d;
                    wrap_q[gi] <= wrap_d;
                end
            end

            assign ns_wrapped[gi] = wrap_q[gi];
        end

        assign alloc_ready     = ns_ok;
        assign issue_id        = cnt_q[alloc_ns];
        assign ns_full         = '0;
        assign err_double_free = 1'b0;
    end else begin : g_recycle
        localparam int ID_N = 2**ID_W;

        logic [ID_N-1:0] map_q [NS_COUNT];
        logic [ID_N-1:0] sel_map;
        logic [ID_W-1:0] low_idx;
        logic            sel_full;
        logic            free_ok;
        logic            free_hit;
        logic            err_q;
        logic            err_d;

        // An invalid select looks full so it can never be accepted.
        assign sel_map = ns_ok ? map_q[alloc_ns] : '1;

        uid_lowest_free #(
            .ID_W(ID_W)
        ) u_lowest_free (
            .bits_i    (sel_map),
            .idx_o     (low_idx),
            .all_set_o (sel_full)
        );

        assign alloc_ready = ns_ok && !sel_full;
        assign issue_id    = low_idx;

        assign free_ok  = free_valid && ns_exists[free_ns];
        assign free_hit = free_ok && map_q[free_ns][free_id];
        assign err_d    = free_ok && !free_hit;

        // The allocated bit is clear pre-edge and the freed bit is set, so they never collide.
        for (genvar gi = 0; gi < NS_COUNT; gi++) begin : g_map
            logic [ID_N-1:0] map_d;

            always_comb begin
                map_d = map_q[gi];
                if (accept && (alloc_ns == NS_W'(gi))) begin
                    map_d[low_idx] = 1'b1;
                end
                if (free_hit && (free_ns == NS_W'(gi))) begin
                    map_d[free_id] = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    map_q[gi] <= '0;
                end else begin
                    map_q[gi] <= map_d;
                end
            end

            assign ns_full[gi] = &map_q[gi];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                err_q <= 1'b0;
            end else begin
                err_q <= err_d;
            end
        end

        assign err_double_free = err_q;
        assign ns_wrapped      = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_ns_q    <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_ns_q <= alloc_ns;
                rsp_id_q <= issue_id;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_ns    = rsp_ns_q;
    assign rsp_id    = rsp_id_q;

endmodule
